stream_idx_fifo: RTL

STREAM_IDX_FIFO -- requirements
Module: stream_idx_fifo

---
 rtl/stream_idx_fifo.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/stream_idx_fifo.sv
// stream_idx_fifo
// Single-clock FIFO that stores a payload together with the omega-network
// source index it came from. Besides the usual valid/ready stream ports it
// keeps one occupancy counter per source index, so pending_o tells which
// sources still have entries in flight. No fall-through, no full bypass.

// Simulation-only consistency checker for stream_idx_fifo.
module stream_idx_fifo_chk (
   input logic clk_i,
   input logic rst_ni,
   input logic idx_bad,
   input logic push_full,
   input logic cnt_ovf,
   input logic cnt_unf
);

   a_idx_range : assert property (@(posedge clk_i) disable iff (!rst_ni) !idx_bad)
      else $error("stream_idx_fifo: idx_i out of range while valid_i is high");

   a_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni) !push_full)
      else $error("stream_idx_fifo: push accepted while full");

   a_cnt_ovf : assert property (@(posedge clk_i) disable iff (!rst_ni) !cnt_ovf)
      else $error("stream_idx_fifo: per-index counter overflow");

   a_cnt_unf : assert property (@(posedge clk_i) disable iff (!rst_ni) !cnt_unf)
      else $error("stream_idx_fifo: per-index counter underflow");

endmodule

module stream_idx_fifo #(
   parameter int unsigned NumInp    = 32'd0,
   parameter int unsigned Depth     = 32'd4,
   parameter int unsigned DataWidth = 32'd1,
   parameter type         payload_t = logic [DataWidth-1:0],
   parameter int unsigned IdxWidth  = (NumInp > 32'd1) ? $clog2(NumInp) : 32'd1,
   parameter int unsigned CntWidth  = $clog2(Depth + 32'd1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  payload_t            data_i,
   input  logic [IdxWidth-1:0] idx_i,
   input  logic                valid_i,
   output logic                ready_o,
   output payload_t            data_o,
   output logic [IdxWidth-1:0] idx_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [CntWidth-1:0] usage_o,
   output logic [NumInp-1:0]   pending_o
);

   typedef logic [IdxWidth-1:0] idx_t;

   // Pointers need at least one bit even for a single-entry FIFO.
   localparam int unsigned PtrWidth = (Depth > 32'd1) ? $clog2(Depth) : 32'd1;
   // Keep at least one counter so the array stays legal for degenerate NumInp.
   localparam int unsigned NumCnt   = (NumInp > 32'd0) ? NumInp : 32'd1;

   typedef logic [PtrWidth-1:0] ptr_t;
   typedef logic [CntWidth-1:0] cnt_t;

   // Advance a pointer, wrapping from the last entry back to zero.
   function automatic ptr_t ptr_inc(input ptr_t p);
      if (p == PtrWidth'(Depth - 32'd1)) begin
         return {PtrWidth{1'b0}};
      end else begin
         return p + PtrWidth'(1'b1);
      end
   endfunction

   payload_t      data_mem_r [Depth];
   idx_t          idx_mem_r  [Depth];
   ptr_t          wr_ptr_r, wr_ptr_nxt_s;
   ptr_t          rd_ptr_r, rd_ptr_nxt_s;
   cnt_t          usage_r, usage_nxt_s;
   cnt_t          cnt_r      [NumCnt];
   cnt_t          cnt_nxt_s  [NumCnt];
   logic [NumInp-1:0] pending_r, pending_nxt_s;

   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;
   idx_t          head_idx_s;
   logic          idx_bad_s;
   logic          cnt_ovf_s;
   logic          cnt_unf_s;

   assign full_s     = (usage_r == CntWidth'(Depth));
   assign empty_s    = (usage_r == {CntWidth{1'b0}});
   assign head_idx_s = idx_mem_r[rd_ptr_r];

   // Handshake decode; a pop in a flush cycle must not touch state.
   always_comb begin
      ready_o = !full_s && !flush_i;
      valid_o = !empty_s;
      push_s  = valid_i && ready_o;
      pop_s   = valid_o && ready_i && !flush_i;
   end

   // Head outputs are forced to zero while nothing is stored.
   always_comb begin
      data_o = '0;
      idx_o  = {IdxWidth{1'b0}};
      if (valid_o) begin
         data_o = data_mem_r[rd_ptr_r];
         idx_o  = head_idx_s;
      end else begin
         data_o = '0;
         idx_o  = {IdxWidth{1'b0}};
      end
   end

   // Next-state for pointers and occupancy.
   always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      usage_nxt_s  = usage_r;
      if (flush_i) begin
         wr_ptr_nxt_s = {PtrWidth{1'b0}};
         rd_ptr_nxt_s = {PtrWidth{1'b0}};
         usage_nxt_s  = {CntWidth{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   usage_nxt_s = usage_r + CntWidth'(1'b1);
            2'b01:   usage_nxt_s = usage_r - CntWidth'(1'b1);
            default: usage_nxt_s = usage_r;
         endcase
      end
   end

   // Next-state for the per-source counters plus over/underflow detection.
   always_comb begin
      cnt_ovf_s = 1'b0;
      cnt_unf_s = 1'b0;
      for (int unsigned i = 0; i < NumCnt; i++) begin
         logic inc_s;
         logic dec_s;
         cnt_nxt_s[i] = cnt_r[i];
         inc_s = push_s && (idx_i == IdxWidth'(i));
         dec_s = pop_s && (head_idx_s == IdxWidth'(i));
         if (flush_i) begin
            cnt_nxt_s[i] = {CntWidth{1'b0}};
         end else begin
            case ({inc_s, dec_s})
               2'b10: begin
                  cnt_nxt_s[i] = cnt_r[i] + CntWidth'(1'b1);
                  if (cnt_r[i] == CntWidth'(Depth)) begin
                     cnt_ovf_s = 1'b1;
                  end else begin
                     cnt_ovf_s = cnt_ovf_s;
                  end
               end
               2'b01: begin
                  cnt_nxt_s[i] = cnt_r[i] - CntWidth'(1'b1);
                  if (cnt_r[i] == {CntWidth{1'b0}}) begin
                     cnt_unf_s = 1'b1;
                  end else begin
                     cnt_unf_s = cnt_unf_s;
                  end
               end
               default: cnt_nxt_s[i] = cnt_r[i];
            endcase
         end
      end
   end

   // Pending flags follow the next counter values so they register with them.
   always_comb begin
      pending_nxt_s = '0;
      for (int unsigned i = 0; i < NumInp; i++) begin
         pending_nxt_s[i] = (cnt_nxt_s[i] != {CntWidth{1'b0}});
      end
   end

   // Pointer, occupancy, counter and pending-flag registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_r  <= {PtrWidth{1'b0}};
         rd_ptr_r  <= {PtrWidth{1'b0}};
         usage_r   <= {CntWidth{1'b0}};
         pending_r <= '0;
         for (int unsigned i = 0; i < NumCnt; i++) begin
            cnt_r[i] <= {CntWidth{1'b0}};
         end
      end else begin
         wr_ptr_r  <= wr_ptr_nxt_s;
         rd_ptr_r  <= rd_ptr_nxt_s;
         usage_r   <= usage_nxt_s;
         pending_r <= pending_nxt_s;
         for (int unsigned i = 0; i < NumCnt; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
      end
   end

   // Entry storage; written only on an accepted push.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            data_mem_r[i] <= '0;
            idx_mem_r[i]  <= {IdxWidth{1'b0}};
         end
      end else if (push_s) begin
         data_mem_r[wr_ptr_r] <= data_i;
         idx_mem_r[wr_ptr_r]  <= idx_i;
      end
   end

   assign usage_o   = usage_r;
   assign pending_o = pending_r;

   assign idx_bad_s = valid_i && (32'(idx_i) >= NumInp);

   stream_idx_fifo_chk u_chk (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .idx_bad   (idx_bad_s),
      .push_full (push_s && full_s),
      .cnt_ovf   (cnt_ovf_s),
      .cnt_unf   (cnt_unf_s)
   );

endmodule
